phy_bist_gen_chk: RTL

Synthesizable, parametrised built-in self-test generator/checker for the PCIe physical-layer datapath. It drives the PHY transmit side with a programmable word stream: counter, LFSR or fixed pattern, with periodic idle (comma) insertion. It also checks the word stream returning from the receive side against a latency-tolerant expected-word FIFO, with lock acquisition, error counting and loss-of-lock detection. It replaces the hand-written stimulus bench so the full PHY loop can be exercised in simulation and on silicon.

---
 rtl/phy_bist_pkg.sv | 13 +
 rtl/phy_bist_fifo.sv | 33 +++
 rtl/phy_bist_gen_chk.sv | 117 +++++++++++
 3 files changed

// File: rtl/phy_bist_pkg.sv
// phy_bist_pkg: shared encodings, checker states and LFSR taps for the PHY BIST
package phy_bist_pkg;
  localparam logic [1:0] MODE_CNT  = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_FIX  = 2'd2;
  localparam logic [1:0] MODE_ALT  = 2'd3;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;
  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCKED} chk_state_t;
  // tap mask for a left-shifting Fibonacci LFSR, bit n-1 set for tap n
  function automatic logic [31:0] lfsr_taps(input int w);
    return (w == 16) ? 32'h0000_D008 : 32'h8020_0003;
  endfunction
endpackage

// File: rtl/phy_bist_fifo.sv
// phy_bist_fifo: synchronous expected-word FIFO with full/empty flags
module phy_bist_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk_f or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  // storage needs no reset; only slots between the pointers are ever read
  always_ff @(posedge clk_f)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/phy_bist_gen_chk.sv
// phy_bist_gen_chk: PHY loopback BIST pattern generator and latency-tolerant checker
module phy_bist_gen_chk
  import phy_bist_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         CNT_W       = 16,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF,
  parameter int         LOSS_THRESH = 4
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [3:0]        valid_gap,
  output logic [DATA_W-1:0] data_input,
  output logic              valid,
  input  logic [DATA_W-1:0] data_output,
  input  logic              valid_out,
  output logic              locked,
  output logic              error,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count,
  output logic              overflow
);
  localparam logic [DATA_W-1:0] IDLE_WORD = {DATA_W/8{IDLE_BYTE}};
  localparam logic [31:0] TAPS32 = lfsr_taps(DATA_W);
  localparam int MW = $clog2(LOSS_THRESH + 1);
  localparam logic [MW-1:0] LOSS_M = MW'(LOSS_THRESH - 1);
  logic              en_q, rise, gap_now, push, pop, hit;
  logic [DATA_W-1:0] pat, cur, nxt, head;
  logic [3:0]        gap_cnt;
  logic              fifo_full, fifo_empty;
  logic [MW-1:0]     miss;
  chk_state_t        state;
  // current word is the freshly loaded seed on the enable rising edge, else the held pattern
  always_comb begin
    rise    = enable && !en_q;
    cur     = rise ? ((mode == MODE_LFSR && seed == '0) ? '1 : seed) : pat;
    nxt     = mode == MODE_CNT  ? cur + 1'b1 :
              mode == MODE_LFSR ? {cur[DATA_W-2:0], ^(cur & TAPS32[DATA_W-1:0])} :
              mode == MODE_FIX  ? cur : ~cur;
    gap_now = valid_gap != '0 && gap_cnt >= valid_gap;
    push    = enable && !gap_now && !fifo_full;
    pop     = valid_out && !fifo_empty && state != ST_IDLE;
    hit     = !fifo_empty && data_output == head;
  end
  // generator: emit and advance only on pushed words; gaps and stalls hold the pattern
  always_ff @(posedge clk_f or negedge reset)
    if (!reset) begin
      en_q       <= 1'b0;
      pat        <= '0;
      gap_cnt    <= '0;
      data_input <= IDLE_WORD;
      valid      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      en_q       <= enable;
      valid      <= push;
      data_input <= push ? cur : IDLE_WORD;
      overflow   <= overflow | (enable && !gap_now && fifo_full);
      if (enable) begin
        pat     <= push ? nxt : cur;
        gap_cnt <= gap_now ? '0 : (push && valid_gap != '0) ? gap_cnt + 1'b1 : gap_cnt;
      end
    end
  phy_bist_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_f(clk_f),
    .reset(reset),
    .push (push),
    .wdata(cur),
    .pop  (pop),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );
  // checker: search for alignment, then count words and misses until lock is lost
  always_ff @(posedge clk_f or negedge reset)
    if (!reset) begin
      state      <= ST_IDLE;
      locked     <= 1'b0;
      error      <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      miss       <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        ST_IDLE: if (enable) state <= ST_SEARCH;
        ST_SEARCH:
          if (valid_out && hit) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
            miss   <= '0;
          end
        ST_LOCKED:
          if (valid_out) begin
            word_count <= (&word_count) ? word_count : word_count + 1'b1;
            if (hit) miss <= '0;
            else begin
              error     <= 1'b1;
              err_count <= (&err_count) ? err_count : err_count + 1'b1;
              if (miss >= LOSS_M) begin
                state  <= ST_SEARCH;
                locked <= 1'b0;
                miss   <= '0;
              end else miss <= miss + 1'b1;
            end
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule
